// File: rtl/rr_mux_nx1_pkg.sv
// Shared constants, state encoding and width helper for the round-robin N:1 mux.
package rr_mux_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    function automatic int sel_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_mux_nx1_if.sv
// Producer-side channels and consumer-side output stream of the N:1 mux.
interface rr_mux_nx1_if
    import rr_mux_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int WIDTH = 8
) ();

    localparam int SEL_W = sel_width(N_CH);

    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_valid;
    logic [N_CH-1:0]       in_ready;
    logic [SEL_W-1:0]      sel;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_ch;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output in_data, in_valid, sel, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    modport slave (
        input  in_data, in_valid, sel, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );

endinterface

// File: rtl/rr_mux_nx1_arbiter.sv
// Combinational rotate-priority arbiter: search starts one past the last winner.
module rr_arbiter #(
    parameter int N_CH  = 8,
    parameter int SEL_W = 3
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             grant_found,
    output logic [SEL_W-1:0] grant_idx
);

    int unsigned idx;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            idx = (32'(ptr) + 32'd1 + k) % N_CH;
            if (!grant_found && req[idx]) begin
                grant_found = 1'b1;
                grant_idx   = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/rr_mux_nx1.sv
// N-channel W-bit multiplexer with one registered output slot and per-channel handshakes.
module rr_mux_nx1
    import rr_mux_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int WIDTH = 8,
    parameter int MODE  = MODE_RR
) (
    input logic         clk,
    input logic         rst,
    rr_mux_nx1_if.slave bus
);

    localparam int SEL_W = sel_width(N_CH);
    localparam int PAD_N = 1 << SEL_W;

    slot_state_t      state;
    logic             load_en;
    logic             xfer;
    logic             grant_found;
    logic [SEL_W-1:0] grant_idx;

    assign load_en       = (state == EMPTY) || bus.out_ready;
    assign xfer          = load_en && grant_found && !rst;
    assign bus.out_valid = (state == FULL);

    generate
        if (MODE == MODE_RR) begin : g_rr
            logic [SEL_W-1:0] ptr;

            rr_arbiter #(
                .N_CH  (N_CH),
                .SEL_W (SEL_W)
            ) u_arb (
                .req         (bus.in_valid),
                .ptr         (ptr),
                .grant_found (grant_found),
                .grant_idx   (grant_idx)
            );

            // Priority only rotates on an actual transfer, never on idle cycles.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    ptr <= SEL_W'(N_CH - 1);
                else if (xfer)
                    ptr <= grant_idx;
            end
        end else begin : g_fixed
            // Zero-padded request vector so out-of-range selects read a 0 bit.
            logic [PAD_N-1:0] req_pad;
            assign req_pad     = PAD_N'(bus.in_valid);
            assign grant_found = req_pad[bus.sel];
            assign grant_idx   = bus.sel;
        end
    endgenerate

    always_comb begin
        bus.in_ready = '0;
        if (xfer)
            bus.in_ready[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= EMPTY;
            bus.out_data <= '0;
            bus.out_ch   <= '0;
        end else if (xfer) begin
            state        <= FULL;
            bus.out_data <= bus.in_data[grant_idx*WIDTH +: WIDTH];
            bus.out_ch   <= grant_idx;
        end else if (bus.out_ready) begin
            state        <= EMPTY;
        end
    end

endmodule

// File: tb/tb_rr_mux_nx1.sv
// Directed bench: round-robin 8-channel instance and fixed-select 6-channel instance.
module tb_rr_mux_nx1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    rr_mux_nx1_if #(.N_CH(8), .WIDTH(8)) ifr ();
    rr_mux_nx1_if #(.N_CH(6), .WIDTH(8)) ifx ();

    rr_mux_nx1 #(.N_CH(8), .WIDTH(8), .MODE(1)) dut_rr (
        .clk (clk),
        .rst (rst),
        .bus (ifr.slave)
    );

    rr_mux_nx1 #(.N_CH(6), .WIDTH(8), .MODE(0)) dut_fx (
        .clk (clk),
        .rst (rst),
        .bus (ifx.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) ifr.in_data[i*8 +: 8] = 8'h10 + 8'(i);
        for (int i = 0; i < 6; i++) ifx.in_data[i*8 +: 8] = 8'h20 + 8'(i);
        ifr.in_valid  = 8'hFF;
        ifr.out_ready = 1'b1;
        ifr.sel       = '0;
        ifx.in_valid  = '0;
        ifx.out_ready = 1'b1;
        ifx.sel       = '0;

        // Reset state
        tick();
        chk("rst_out_valid", 32'(ifr.out_valid), 0);
        chk("rst_out_data",  32'(ifr.out_data),  0);
        chk("rst_out_ch",    32'(ifr.out_ch),    0);
        chk("rst_in_ready",  32'(ifr.in_ready),  0);
        rst = 1'b0;

        // Full round-robin sweep, one word per cycle
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("sweep_ch",    32'(ifr.out_ch),    32'(i % 8));
            chk("sweep_data",  32'(ifr.out_data),  32'(8'h10 + 8'(i % 8)));
            chk("sweep_valid", 32'(ifr.out_valid), 1);
        end

        // Skip non-requesting channels: 2,5,7,2,5
        ifr.in_valid = 8'b1010_0100;
        tick(); chk("skip_ch0", 32'(ifr.out_ch), 2);
        tick(); chk("skip_ch1", 32'(ifr.out_ch), 5);
        tick(); chk("skip_ch2", 32'(ifr.out_ch), 7);
        tick(); chk("skip_ch3", 32'(ifr.out_ch), 2);
        tick(); chk("skip_ch4", 32'(ifr.out_ch), 5);

        // Backpressure on a single channel 3
        ifr.in_valid        = 8'b0000_1000;
        ifr.in_data[24 +: 8] = 8'hA5;
        tick();
        chk("bp_load_ch",   32'(ifr.out_ch),   3);
        chk("bp_load_data", 32'(ifr.out_data), 32'h A5);
        ifr.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_in_ready", 32'(ifr.in_ready), 0);
            tick();
            chk("bp_hold_valid", 32'(ifr.out_valid), 1);
            chk("bp_hold_data",  32'(ifr.out_data),  32'hA5);
        end
        ifr.in_data[24 +: 8] = 8'h5A;
        ifr.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(ifr.in_ready), 32'h08);
        tick();
        chk("bp_reload_valid", 32'(ifr.out_valid), 1);
        chk("bp_reload_data",  32'(ifr.out_data),  32'h5A);
        ifr.in_valid = '0;
        tick();
        chk("drain_valid", 32'(ifr.out_valid), 0);
        chk("drain_hold",  32'(ifr.out_data),  32'h5A);

        // Asynchronous reset while stalled with a held word
        ifr.in_valid = 8'b0000_1000;
        tick();
        ifr.out_ready = 1'b0;
        tick();
        chk("stall_valid", 32'(ifr.out_valid), 1);
        rst = 1'b1;
        #1;
        chk("async_valid",    32'(ifr.out_valid), 0);
        chk("async_data",     32'(ifr.out_data),  0);
        chk("async_in_ready", 32'(ifr.in_ready),  0);
        for (int i = 0; i < 8; i++) ifr.in_data[i*8 +: 8] = 8'h10 + 8'(i);
        ifr.in_valid  = 8'hFF;
        ifr.out_ready = 1'b1;
        #1;
        rst = 1'b0;
        tick();
        chk("post_rst_ch",   32'(ifr.out_ch),   0);
        chk("post_rst_data", 32'(ifr.out_data), 32'h10);

        // Fixed select on the 6-channel instance
        ifx.in_valid = 6'h3F;
        ifx.sel      = 3'd4;
        tick();
        chk("fx_sel4_ch",    32'(ifx.out_ch),    4);
        chk("fx_sel4_data",  32'(ifx.out_data),  32'h24);
        chk("fx_sel4_valid", 32'(ifx.out_valid), 1);
        ifx.sel = 3'd1;
        tick();
        chk("fx_sel1_ch",   32'(ifx.out_ch),   1);
        chk("fx_sel1_data", 32'(ifx.out_data), 32'h21);
        ifx.sel = 3'd7;
        #1;
        chk("fx_sel7_ready", 32'(ifx.in_ready), 0);
        tick();
        chk("fx_sel7_valid", 32'(ifx.out_valid), 0);
        chk("fx_sel7_hold",  32'(ifx.out_ch),    1);
        ifx.sel = 3'd6;
        #1;
        chk("fx_sel6_ready", 32'(ifx.in_ready), 0);
        ifx.sel = 3'd5;
        #1;
        chk("fx_sel5_ready", 32'(ifx.in_ready), 32'h20);
        tick();
        chk("fx_sel5_ch",   32'(ifx.out_ch),   5);
        chk("fx_sel5_data", 32'(ifx.out_data), 32'h25);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rr_mux_nx1.md
# rr_mux_nx1

Parametrised N-channel, W-bit multiplexer with a registered output stage and per-channel valid/ready handshakes. It is the sequential successor of the fixed 8x1 bit multiplexer. It selects one requesting channel per cycle, either from an external select or by round-robin arbitration, and presents the winner on a single output stream. It sits between multiple producer channels and one shared consumer, for example a shared bus or a serialiser.

## Interface
Parameters:
- N_CH, 8, number of input channels (2..32, need not be a power of two)
- WIDTH, 8, data width per channel
- MODE, 1, 0 = fixed select from `sel`, 1 = round-robin arbitration
- SEL_W, $clog2(N_CH), select and channel-index width (derived, not overridden)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_data  in  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  N_CH  per-channel valid
- in_ready  out  N_CH  per-channel ready, combinational, at most one bit high
- sel  in  SEL_W  channel select, used only when MODE=0
- out_data  out  WIDTH  registered output word
- out_ch  out  SEL_W  index of the channel that supplied out_data
- out_valid  out  1  output word valid
- out_ready  in  1  consumer accepts the word

## Operation
- Output stage is a single register slot: `out_data`, `out_ch`, `out_valid`.
- `load_en = !out_valid || out_ready`. The slot is empty or is being drained this cycle.
- Grant, MODE=0:
  - Channel `sel` is granted if `sel < N_CH` and `in_valid[sel]`.
  - `sel >= N_CH` grants nothing.
- Grant, MODE=1:
  - Priority search over valid channels starts at `(ptr+1) mod N_CH` and wraps around.
  - The first valid channel found wins.
- `in_ready[g] = load_en && grant_found`, for granted channel g only. All other bits are 0.
- Transfer on channel g: `in_valid[g] && in_ready[g]`. On the next edge:
  - `out_data <= in_data[g]`
  - `out_ch <= g`
  - `out_valid <= 1`
  - `ptr <= g` (MODE=1 only)
- Drain without a reload, when `out_valid && out_ready` and no grant: `out_valid <= 0`. `out_data` and `out_ch` hold.
- `ptr` changes only on a transfer. Idle cycles do not rotate priority.
- Arbitration state: `ptr` (SEL_W bits). The FSM is implicit with two states:
  - EMPTY (`out_valid=0`) goes to FULL on a transfer.
  - FULL goes to EMPTY on a drain with no transfer.
  - FULL stays FULL (reload) on a drain with a transfer.
  - FULL stays FULL (stall) when `out_ready=0`.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_ch=0`, `ptr=N_CH-1`. After reset, channel 0 has first priority. `in_ready` is 0 while `rst` is high.
- Latency: an input accepted at edge k appears on `out_*` after edge k.
- Throughput: one word per cycle when `out_ready` is held high. Back-to-back reloads require no bubble.
- Stall (`out_valid=1`, `out_ready=0`):
  - All `in_ready` bits are 0.
  - `out_data`, `out_ch` and `out_valid` are held stable.
- Simultaneous drain and load in the same cycle: the new word replaces the old one. No loss, no duplication.
- `in_valid` may drop without a transfer. Arbitration is re-evaluated every cycle.
- MODE=0: `sel` may change every cycle. Only its value in the transfer cycle matters.
- Reset asserted mid-operation: the held word is discarded and `out_valid` clears immediately (asynchronously). `ptr` returns to `N_CH-1`.

## Structure
- Shared package `rr_mux_pkg`: constants `MODE_FIXED=0`, `MODE_RR=1`, and a function `sel_width(n)` returning `max(1, $clog2(n))`.
- Sub-module `rr_arbiter`: combinational rotate-priority arbiter.
  - Inputs: `req[N_CH]`, `ptr`.
  - Outputs: `grant_found`, `grant_idx`.
  - Instantiated only for MODE=1.
- Top level holds the output register, `ptr`, and the data mux. The data mux is an indexed part-select, not an AND-OR tree.

## Test plan
- Reset check, MODE=1, N_CH=8, WIDTH=8, all `in_valid=1`, `out_ready=1`, channel i data `8'h10+i`, release `rst`:
  - `out_ch` sequence 0,1,...,7,0 on consecutive cycles.
  - Data sequence `8'h10`..`8'h17`.
- Round-robin skip, MODE=1, `in_valid=8'b1010_0100`, `out_ready=1`: grants cycle 2,5,7,2,...
- Backpressure, single valid channel 3 with data `8'hA5`, `out_ready=0` for 4 cycles:
  - `out_valid=1` and `out_data=8'hA5` are held.
  - `in_ready=0` for 4 cycles.
  - On release, the next word loads in the same cycle as the drain.
- Fixed select, MODE=0, N_CH=6, all valid:
  - `sel=4` gives `out_ch=4`.
  - `sel=7` (out of range) gives no transfer and `out_valid` falls to 0 after the drain.
- Async reset with `out_valid=1` mid-stall: `out_valid` goes to 0 before the next clock edge. The first grant after reset is channel 0.
